fetch_pc_sequencer: RTL and testbench

- Owns the fetch program counter and drives the frontend's `pc_in`, advancing it as the fetch→decode handshake accepts instructions.
- Sequences redirects: backend mispredicts and decode-time jumps.
- Produces the frontend flush strobe and inserts a programmable bubble after each redirect.
- Supports a halt request.
- Sits between the commit/branch-resolution logic and the fetch unit.

---
 rtl/fetch_pc_sequencer_pkg.sv | 18 +
 rtl/fetch_pc_sequencer_if.sv | 24 ++
 rtl/fetch_pc_sequencer_sat_counter.sv | 21 ++
 rtl/fetch_pc_sequencer.sv | 111 +++++++++++
 tb/tb_fetch_pc_sequencer.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pc_sequencer_pkg.sv
// Shared types and constants for the fetch PC sequencer.
package fetch_pc_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2,
    HALT   = 2'd3
  } seq_state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Redirect targets are forced to word alignment.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_sequencer_if.sv
// Fetch-side handshake and redirect bus between sequencer (master) and frontend/backend (slave).
interface fetch_pc_sequencer_if;
  import fetch_pc_sequencer_pkg::*;

  logic        fetch_ready;
  logic        mispredict;
  logic [31:0] mispredict_target;
  logic        jump_valid;
  logic [31:0] jump_target;
  logic        halt_req;
  logic [31:0] pc_out;
  logic        pc_valid;
  logic        flush_out;

  modport master (
    input  fetch_ready, mispredict, mispredict_target, jump_valid, jump_target, halt_req,
    output pc_out, pc_valid, flush_out
  );

  modport slave (
    output fetch_ready, mispredict, mispredict_target, jump_valid, jump_target, halt_req,
    input  pc_out, pc_valid, flush_out
  );
endinterface

// File: rtl/fetch_pc_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; reusable for performance counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + W'(1);
  end

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Fetch PC owner: advances on accepted fetches, applies mispredict/jump redirects
// with a flush strobe and a post-redirect bubble, and honours halt requests.
module fetch_pc_sequencer
  import fetch_pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          BUBBLE_CYCLES = 2,
  parameter int          CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_pc_sequencer_if.master bus,
  output logic [1:0]           seq_state,
  output logic [CNT_W-1:0]     redirect_count
);

  localparam logic [3:0] BUBBLE_INIT = 4'(BUBBLE_CYCLES - 1);

  seq_state_t  state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        valid, valid_nxt;
  logic        flush, flush_nxt;
  logic [3:0]  bub_cnt, bub_nxt;
  logic        redirect;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      valid   <= 1'b0;
      flush   <= 1'b0;
      bub_cnt <= 4'd0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      valid   <= valid_nxt;
      flush   <= flush_nxt;
      bub_cnt <= bub_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    valid_nxt = valid;
    flush_nxt = 1'b0;
    bub_nxt   = bub_cnt;
    redirect  = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = RUN;
        valid_nxt = 1'b1;
      end
      default: begin
        // Mispredict wins over a same-cycle jump; the jump is simply discarded.
        if (bus.mispredict || bus.jump_valid) begin
          redirect  = 1'b1;
          flush_nxt = 1'b1;
          pc_nxt    = align_pc(bus.mispredict ? bus.mispredict_target : bus.jump_target);
          if (state != HALT) begin
            state_nxt = BUBBLE;
            valid_nxt = 1'b0;
            bub_nxt   = BUBBLE_INIT;
          end
        end else begin
          case (state)
            RUN: begin
              if (bus.halt_req) begin
                state_nxt = HALT;
                valid_nxt = 1'b0;
              end else if (valid && bus.fetch_ready) begin
                pc_nxt = pc + PC_STEP;
              end
            end
            BUBBLE: begin
              if (bub_cnt != 4'd0) begin
                bub_nxt = bub_cnt - 4'd1;
              end else if (bus.halt_req) begin
                state_nxt = HALT;
              end else begin
                state_nxt = RUN;
                valid_nxt = 1'b1;
              end
            end
            HALT: begin
              if (!bus.halt_req) begin
                state_nxt = RUN;
                valid_nxt = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  assign bus.pc_out    = pc;
  assign bus.pc_valid  = valid;
  assign bus.flush_out = flush;
  assign seq_state     = state;

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .rst   (reset),
    .inc   (redirect),
    .clear (1'b0),
    .count (redirect_count)
  );

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Bench for fetch_pc_sequencer: directed vector table, corner sequences and a
// randomized run against a behavioural model of the sequencing rules.
module tb_fetch_pc_sequencer;

  localparam logic [31:0] RPC    = 32'h0000_0100;
  localparam int          BC     = 2;
  localparam int          CW     = 16;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_pc_sequencer_if bus ();
  fetch_pc_sequencer_if bus2 ();
  logic [1:0]    st, st2;
  logic [CW-1:0] rc;
  logic [1:0]    rc2;

  fetch_pc_sequencer #(.RESET_PC(RPC), .BUBBLE_CYCLES(BC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus), .seq_state(st), .redirect_count(rc)
  );

  fetch_pc_sequencer #(.RESET_PC(32'h0), .BUBBLE_CYCLES(BC), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2), .seq_state(st2), .redirect_count(rc2)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model: mode 0 idle, 1 run, 2 bubble, 3 halt
  int          m_mode, m_cnt, m_resume, cyc;
  logic [31:0] m_pc;
  logic        m_valid, m_flush;

  typedef struct {
    logic [3:0]  ctl;   // {fetch_ready, mispredict, jump_valid, halt_req}
    logic [31:0] mt;
    logic [31:0] jt;
    logic [31:0] pc;
    logic [1:0]  vf;    // {pc_valid, flush_out}
    logic [1:0]  st;
    logic [15:0] cnt;
  } vec_t;
  vec_t tbl [24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = RPC; m_valid = 1'b0; m_flush = 1'b0;
    m_cnt = 0; m_resume = 0; cyc = 0;
  endtask

  task automatic model_step(input logic fr, input logic mp, input logic [31:0] mt,
                            input logic jv, input logic [31:0] jt, input logic hr);
    cyc++;
    m_flush = 1'b0;
    if (m_mode == 0) begin
      m_mode = 1; m_valid = 1'b1;
      return;
    end
    if (mp || jv) begin
      m_pc = (mp ? mt : jt) & 32'hFFFF_FFFC;
      m_flush = 1'b1;
      if (m_cnt < CNT_MAX) m_cnt++;
      if (m_mode != 3) begin
        m_mode = 2; m_valid = 1'b0; m_resume = cyc + BC;
      end
      return;
    end
    case (m_mode)
      1: if (hr) begin m_mode = 3; m_valid = 1'b0; end
         else if (fr) m_pc = m_pc + 32'd4;
      2: if (cyc >= m_resume) begin
           if (hr) m_mode = 3;
           else begin m_mode = 1; m_valid = 1'b1; end
         end
      3: if (!hr) begin m_mode = 1; m_valid = 1'b1; end
      default: ;
    endcase
  endtask

  task automatic step(input string tag, input logic fr, input logic mp, input logic [31:0] mt,
                      input logic jv, input logic [31:0] jt, input logic hr);
    bus.fetch_ready = fr; bus.mispredict = mp; bus.mispredict_target = mt;
    bus.jump_valid = jv; bus.jump_target = jt; bus.halt_req = hr;
    @(posedge clk);
    model_step(fr, mp, mt, jv, jt, hr);
    #1;
    chk({tag, " pc"},    bus.pc_out, m_pc);
    chk({tag, " valid"}, 32'(bus.pc_valid), 32'(m_valid));
    chk({tag, " flush"}, 32'(bus.flush_out), 32'(m_flush));
    chk({tag, " state"}, 32'(st), m_mode);
    chk({tag, " count"}, 32'(rc), m_cnt);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, " pc"},    bus.pc_out, RPC);
    chk({tag, " valid"}, 32'(bus.pc_valid), 32'd0);
    chk({tag, " flush"}, 32'(bus.flush_out), 32'd0);
    chk({tag, " state"}, 32'(st), 32'd0);
    chk({tag, " count"}, 32'(rc), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic hr_r;
    string t;

    tbl[0]  = '{4'b1100, 32'h9000, 32'h0,   32'h100,  2'b10, 2'd1, 16'd0};
    tbl[1]  = '{4'b1000, 32'h0,    32'h0,   32'h104,  2'b10, 2'd1, 16'd0};
    tbl[2]  = '{4'b1000, 32'h0,    32'h0,   32'h108,  2'b10, 2'd1, 16'd0};
    tbl[3]  = '{4'b0000, 32'h0,    32'h0,   32'h108,  2'b10, 2'd1, 16'd0};
    tbl[4]  = '{4'b0000, 32'h0,    32'h0,   32'h108,  2'b10, 2'd1, 16'd0};
    tbl[5]  = '{4'b0000, 32'h0,    32'h0,   32'h108,  2'b10, 2'd1, 16'd0};
    tbl[6]  = '{4'b1000, 32'h0,    32'h0,   32'h10C,  2'b10, 2'd1, 16'd0};
    tbl[7]  = '{4'b1100, 32'h2003, 32'h0,   32'h2000, 2'b01, 2'd2, 16'd1};
    tbl[8]  = '{4'b1000, 32'h0,    32'h0,   32'h2000, 2'b00, 2'd2, 16'd1};
    tbl[9]  = '{4'b1000, 32'h0,    32'h0,   32'h2000, 2'b10, 2'd1, 16'd1};
    tbl[10] = '{4'b1110, 32'h3000, 32'h4000, 32'h3000, 2'b01, 2'd2, 16'd2};
    tbl[11] = '{4'b1001, 32'h0,    32'h0,   32'h3000, 2'b00, 2'd2, 16'd2};
    tbl[12] = '{4'b1001, 32'h0,    32'h0,   32'h3000, 2'b00, 2'd3, 16'd2};
    tbl[13] = '{4'b1011, 32'h0,    32'h500, 32'h500,  2'b01, 2'd3, 16'd3};
    tbl[14] = '{4'b1001, 32'h0,    32'h0,   32'h500,  2'b00, 2'd3, 16'd3};
    tbl[15] = '{4'b1000, 32'h0,    32'h0,   32'h500,  2'b10, 2'd1, 16'd3};
    tbl[16] = '{4'b1000, 32'h0,    32'h0,   32'h504,  2'b10, 2'd1, 16'd3};
    tbl[17] = '{4'b1001, 32'h0,    32'h0,   32'h504,  2'b00, 2'd3, 16'd3};
    tbl[18] = '{4'b1000, 32'h0,    32'h0,   32'h504,  2'b10, 2'd1, 16'd3};
    tbl[19] = '{4'b0010, 32'h0,    32'h600, 32'h600,  2'b01, 2'd2, 16'd4};
    tbl[20] = '{4'b0100, 32'h7001, 32'h0,   32'h7000, 2'b01, 2'd2, 16'd5};
    tbl[21] = '{4'b0000, 32'h0,    32'h0,   32'h7000, 2'b00, 2'd2, 16'd5};
    tbl[22] = '{4'b0000, 32'h0,    32'h0,   32'h7000, 2'b10, 2'd1, 16'd5};
    tbl[23] = '{4'b1000, 32'h0,    32'h0,   32'h7004, 2'b10, 2'd1, 16'd5};

    bus2.fetch_ready = 1'b0; bus2.mispredict = 1'b0; bus2.mispredict_target = 32'h0;
    bus2.jump_valid = 1'b0; bus2.jump_target = 32'h0; bus2.halt_req = 1'b0;
    bus.fetch_ready = 1'b0; bus.mispredict = 1'b0; bus.mispredict_target = 32'h0;
    bus.jump_valid = 1'b0; bus.jump_target = 32'h0; bus.halt_req = 1'b0;

    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_values("reset");
    reset = 1'b0;

    // Directed table; row 0 also shows a mispredict in IDLE being ignored.
    for (int i = 0; i < 24; i++) begin
      t = $sformatf("vec%0d", i);
      step(t, tbl[i].ctl[3], tbl[i].ctl[2], tbl[i].mt, tbl[i].ctl[1], tbl[i].jt, tbl[i].ctl[0]);
      chk({t, " tbl_pc"},    bus.pc_out, tbl[i].pc);
      chk({t, " tbl_vf"},    32'({bus.pc_valid, bus.flush_out}), 32'(tbl[i].vf));
      chk({t, " tbl_state"}, 32'(st), 32'(tbl[i].st));
      chk({t, " tbl_count"}, 32'(rc), 32'(tbl[i].cnt));
    end

    // PC wrap at the top of the address space.
    step("wrap_redir", 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0, 1'b0);
    chk("wrap_target", bus.pc_out, 32'hFFFF_FFFC);
    step("wrap_b1", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step("wrap_b2", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step("wrap_adv", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("wrap_zero", bus.pc_out, 32'h0);

    // Narrow redirect counter saturates at 3 on the second instance.
    for (int i = 1; i <= 5; i++) begin
      bus2.mispredict = 1'b1;
      bus2.mispredict_target = 32'(i * 64);
      step("sat_idle", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      chk($sformatf("sat_count%0d", i), 32'(rc2), (i < 3) ? i : 3);
    end
    bus2.mispredict = 1'b0;
    step("sat_after", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("sat_hold", 32'(rc2), 32'd3);

    // Randomized run against the model.
    hr_r = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) hr_r = ~hr_r;
      step($sformatf("rnd%0d", i),
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 9) == 0), $urandom,
           1'($urandom_range(0, 7) == 0), $urandom,
           hr_r);
    end

    // Asynchronous reset in the middle of a bubble.
    step("ar_redir", 1'b1, 1'b1, 32'h8888, 1'b0, 32'h0, 1'b0);
    step("ar_bub", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("ar_in_bubble", 32'(st), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_values("async_reset");
    chk("async_reset cnt2", 32'(rc2), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("post_reset", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step("post_run", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("post_run_pc", bus.pc_out, RPC + 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
